cla_seq_ctrl: RTL and testbench
===============================

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES, NIBBLES >= 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  controller can accept an operand set.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  registered carry-out of the MSB.
REQ-013 The block SHALL instantiate exactly one 4-bit carry-lookahead adder (module cla) and time-share it across all slices, LSB slice first.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: in_ready=1, out_valid=0; when in_valid&in_ready at an edge, latch a, b and cin, clear slice index, go to RUN.
REQ-016 RUN: each cycle, feed slice[idx] of a/b plus the carry register to the adder; at the edge, write the adder sum into sum[4*idx+3:4*idx], load the carry register from the adder carry-out, and increment idx.
REQ-017 RUN to DONE on the edge that processes slice NIBBLES-1; cout takes that final carry.
REQ-018 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge (4 cycles at default).
REQ-019 DONE: out_valid=1; sum and cout SHALL hold stable until out_valid&out_ready at an edge, then go to IDLE.
REQ-020 in_ready=0 in RUN and DONE; in_valid there is ignored, and latched operands do not change.
REQ-021 in_valid in the same cycle the DONE handshake completes SHALL be accepted no earlier than the following cycle (IDLE).
REQ-022 Throughput: at most one operation per NIBBLES+2 cycles.
REQ-023 Arithmetic is modulo 2^W; the carry out of the top slice appears only on cout, and no wrap into sum bit 0.
REQ-024 sum and cout SHALL keep the last result in IDLE until the next RUN overwrites them slice by slice.

Reset
REQ-025 When rst_n is low: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry register and idx=0, latched operands=0.
REQ-026 Reset in RUN or DONE SHALL abort the operation immediately; no partial result is ever flagged valid.
REQ-027 The first operand set is accepted on the first rising edge with rst_n high and in_valid high.

Configuration
REQ-028 Macro CLA_SEQ_OVF_EN: when defined, add output port ovf (1 bit), registered with cout, equal to signed overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]). It resets to 0 and holds with sum.
REQ-029 When CLA_SEQ_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 a=0x0003, b=0x0005, cin=0 accepted at edge T -> out_valid at T+4, sum=0x0008, cout=0.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 slices); a=0x0006, b=0x0002, cin=1 -> sum=0x0009, cout=0.
REQ-032 Hold out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid stay constant and in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-033 Pulse rst_n low two cycles after acceptance of 0x1234+0x1111 -> outputs go to reset values asynchronously; after release in_ready=1, out_valid never asserts for the aborted operation.
REQ-034 Toggle in_valid with new operands during RUN -> result equals the originally accepted operands.
REQ-035 With CLA_SEQ_OVF_EN defined: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.

Source files
------------

// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential carry-lookahead adder.
// The ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CLA_SEQ_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CLA_SEQ_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Sequential W-bit adder: one 4-bit carry-lookahead adder time-shared over
// NIBBLES slices, LSB first. Define CLA_SEQ_OVF_EN to add the signed-overflow flag.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];
  assign co   = c[4];
endmodule

module cla_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_seq_ctrl_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       sum_reg;
  logic               carry_reg;
  logic               cout_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [3:0]         a_sl [NIBBLES];
  logic [3:0]         b_sl [NIBBLES];
  logic [3:0]         slice_a;
  logic [3:0]         slice_b;
  logic [3:0]         cla_s;
  logic               cla_co;
  logic               last_slice;
  logic               accept;
  logic               release_res;
`ifdef CLA_SEQ_OVF_EN
  logic               ovf_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[4*gi +: 4];
      assign b_sl[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign slice_a = a_sl[idx_reg];
  assign slice_b = b_sl[idx_reg];

  cla u_cla (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_reg),
    .s  (cla_s),
    .co (cla_co)
  );

  assign last_slice  = (idx_reg == IDX_W'(NIBBLES - 1));
  assign accept      = (state_reg == IDLE) && bus.in_valid;
  assign release_res = (state_reg == DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)      state_next = RUN;
      RUN:     if (last_slice)  state_next = DONE;
      DONE:    if (release_res) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg == DONE);
  end

  // Operands are only captured in IDLE, so in_valid during RUN/DONE cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg[4*idx_reg +: 4] <= cla_s;
          carry_reg               <= cla_co;
          if (last_slice) begin
            idx_reg  <= '0;
            cout_reg <= cla_co;
`ifdef CLA_SEQ_OVF_EN
            // Overflow when both operands share a sign the result does not.
            ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (cla_s[3] != a_reg[W-1]);
`endif
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
`ifdef CLA_SEQ_OVF_EN
  assign bus.ovf  = ovf_reg;
`endif
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed-vector bench for cla_seq_ctrl (NIBBLES=4): latency, hold, abort, arithmetic.
// Covers the ovf flag when built with CLA_SEQ_OVF_EN.
module tb_cla_seq_ctrl;
  localparam int NIB = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  cla_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

  cla_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: offer, count latency, optional stall, then handshake.
  task automatic run_op(input logic [15:0] ea, input logic [15:0] eb, input logic ec,
                        input logic [15:0] es, input logic eco, input logic eov,
                        input int hold, input bit noise, input bit early);
    bus.a        = ea;
    bus.b        = eb;
    bus.cin      = ec;
    bus.in_valid = 1'b1;
    chk("accept_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= NIB; k++) begin
      chk("latency_no_valid", bus.out_valid, 1'b0);
      chk("run_not_ready", bus.in_ready, 1'b0);
      if (noise) begin
        bus.in_valid = k[0];
        bus.a        = ~ea;
        bus.b        = ea ^ 16'h5A5A;
        bus.cin      = ~ec;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("latency_valid", bus.out_valid, 1'b1);
    chk("sum", bus.sum, es);
    chk("cout", bus.cout, eco);
`ifdef CLA_SEQ_OVF_EN
    chk("ovf", bus.ovf, eov);
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_ready", bus.in_ready, 1'b0);
      chk("hold_sum", bus.sum, es);
      chk("hold_cout", bus.cout, eco);
    end
    bus.out_ready = 1'b1;
    if (early) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'hAAAA;
      bus.b        = 16'h5555;
    end
    tick();
    bus.out_ready = 1'b0;
    chk("idle_ready", bus.in_ready, 1'b1);
    chk("idle_no_valid", bus.out_valid, 1'b0);
    chk("idle_keep_sum", bus.sum, es);
    chk("idle_keep_cout", bus.cout, eco);
    bus.in_valid = 1'b0;
    $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d (ovf ref %0d)", ea, eb, ec, bus.sum, bus.cout, eov);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", bus.cout, 1'b0);
    tick();
    rst_n = 1'b1;

    run_op(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    run_op(16'h0006, 16'h0002, 1'b1, 16'h0009, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Abort: reset two cycles into an operation must clear everything at once.
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_sum", bus.sum, 16'h0000);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("abort_never_valid", bus.out_valid, 1'b0);
      chk("abort_idle_ready", bus.in_ready, 1'b1);
      tick();
    end

    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
